// File: rtl/puf_challenge_seq_if.sv
// Bundles the two handshake buses of puf_challenge_seq:
//   - generator side : rwc_enable/rwc_data/rwc_addr out, rwc_available/rwc_rsp_pos/rwc_rsp_neg back
//   - response side  : rsp_valid/rsp_pos/rsp_neg/rsp_idx out, rsp_ready back
// The master modport is the sequencer view; slave is the generator/consumer view.
interface puf_challenge_seq_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              rwc_enable;
  logic [DATA_W-1:0] rwc_data;
  logic [ADDR_W-1:0] rwc_addr;
  logic              rwc_available;
  logic [DATA_W-1:0] rwc_rsp_pos;
  logic [DATA_W-1:0] rwc_rsp_neg;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_pos;
  logic [DATA_W-1:0] rsp_neg;
  logic [ADDR_W-1:0] rsp_idx;

  modport master (
    output rwc_enable, rwc_data, rwc_addr,
    input  rwc_available, rwc_rsp_pos, rwc_rsp_neg,
    output rsp_valid, rsp_pos, rsp_neg, rsp_idx,
    input  rsp_ready
  );

  modport slave (
    input  rwc_enable, rwc_data, rwc_addr,
    output rwc_available, rwc_rsp_pos, rwc_rsp_neg,
    input  rsp_valid, rsp_pos, rsp_neg, rsp_idx,
    output rsp_ready
  );
endinterface

// File: rtl/puf_challenge_seq.sv
// PUF challenge sequencer: walks NUM_CHAL challenges starting at base_addr, fires each one
// at the collision generator, waits for its result, rests REST_CYCLES after every
// evaluation, then hands the response out on a valid/ready port.
// Optional feature macro: PUF_MAJORITY_VOTE_EN -- evaluate each challenge NUM_EVAL times and
// output the per-bit majority; without it one evaluation is taken and passed through.
// Ports:
//   w_clk, w_resetn   : clock, synchronous active-low reset
//   start             : level-sampled run request (only looked at while idle)
//   base_data/addr    : challenge seed and first address, loaded on start
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   bus (master)      : generator handshake (rwc_*) and response handshake (rsp_*)
module puf_challenge_seq #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned NUM_CHAL    = 16,
  parameter int unsigned NUM_EVAL    = 5,
  parameter int unsigned REST_CYCLES = 150_000_000
) (
  input  logic                w_clk,
  input  logic                w_resetn,
  input  logic                start,
  input  logic [DATA_W-1:0]   base_data,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  puf_challenge_seq_if.master bus
);

  localparam int unsigned REST_W = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;
  localparam int unsigned EVAL_W = $clog2(NUM_EVAL + 1);
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned EVALS = NUM_EVAL;
`else
  localparam int unsigned EVALS = 1;
`endif

  typedef enum logic [2:0] {IDLE, FIRE, WAIT, REST, EMIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   base_data_q, base_data_d;
  logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
  logic [ADDR_W-1:0]   chal_idx_q, chal_idx_d;
  logic [EVAL_W-1:0]   eval_cnt_q, eval_cnt_d;
  logic [REST_W-1:0]   rest_cnt_q, rest_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rwc_enable_q, rwc_enable_d;
  logic [DATA_W-1:0]   rwc_data_q, rwc_data_d;
  logic [ADDR_W-1:0]   rwc_addr_q, rwc_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_pos_q, rsp_pos_d;
  logic [DATA_W-1:0]   rsp_neg_q, rsp_neg_d;
  logic [ADDR_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic                new_chal;  // entering FIRE for a fresh challenge
  logic                capture;   // generator result taken this cycle
  logic [DATA_W-1:0]   vote_pos, vote_neg;

  // Rotate left by idx mod DATA_W; a zero shift leaves x>>DATA_W = 0, so no special case
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                             input logic [ADDR_W-1:0] idx);
    int unsigned sh;
    sh = 32'(idx) % DATA_W;
    return (x << sh) | (x >> (DATA_W - sh));
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    base_data_d = base_data_q;
    base_addr_d = base_addr_q;
    chal_idx_d  = chal_idx_q;
    eval_cnt_d  = eval_cnt_q;
    rest_cnt_d  = rest_cnt_q;
    rwc_data_d  = rwc_data_q;
    rwc_addr_d  = rwc_addr_q;
    rsp_pos_d   = rsp_pos_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_idx_d   = rsp_idx_q;
    done_d      = 1'b0;
    new_chal    = 1'b0;
    capture     = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        base_data_d = base_data;
        base_addr_d = base_addr;
        chal_idx_d  = '0;
        eval_cnt_d  = '0;
        new_chal    = 1'b1;
        state_d     = FIRE;
      end
      FIRE: state_d = WAIT;
      WAIT: if (bus.rwc_available) begin
        capture    = 1'b1;
        rest_cnt_d = '0;
        state_d    = REST;
      end
      REST: begin
        if (rest_cnt_q == REST_W'(REST_CYCLES - 1)) begin
          if (eval_cnt_q != EVAL_W'(EVALS - 1)) begin
            eval_cnt_d = eval_cnt_q + EVAL_W'(1);
            state_d    = FIRE;
          end else begin
            rsp_pos_d = vote_pos;
            rsp_neg_d = vote_neg;
            rsp_idx_d = chal_idx_q;
            state_d   = EMIT;
          end
        end else begin
          rest_cnt_d = rest_cnt_q + REST_W'(1);
        end
      end
      EMIT: if (bus.rsp_ready) begin
        if (chal_idx_q == ADDR_W'(NUM_CHAL - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          chal_idx_d = chal_idx_q + ADDR_W'(1);
          eval_cnt_d = '0;
          new_chal   = 1'b1;
          state_d    = FIRE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Challenge only changes at challenge boundaries, so it stays put through every REST
    if (new_chal) begin
      rwc_addr_d = base_addr_d + chal_idx_d;
      rwc_data_d = rotl(base_data_d, chal_idx_d);
    end

    busy_d       = (state_d != IDLE);
    rwc_enable_d = (state_d == FIRE);
    rsp_valid_d  = (state_d == EMIT);
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      state_q      <= IDLE;
      base_data_q  <= '0;
      base_addr_q  <= '0;
      chal_idx_q   <= '0;
      eval_cnt_q   <= '0;
      rest_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rwc_enable_q <= 1'b0;
      rwc_data_q   <= '0;
      rwc_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_pos_q    <= '0;
      rsp_neg_q    <= '0;
      rsp_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_data_q  <= base_data_d;
      base_addr_q  <= base_addr_d;
      chal_idx_q   <= chal_idx_d;
      eval_cnt_q   <= eval_cnt_d;
      rest_cnt_q   <= rest_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rwc_enable_q <= rwc_enable_d;
      rwc_data_q   <= rwc_data_d;
      rwc_addr_q   <= rwc_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pos_q    <= rsp_pos_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_idx_q    <= rsp_idx_d;
    end
  end

`ifdef PUF_MAJORITY_VOTE_EN
  // Per-bit one-counters, cleared whenever a new challenge starts
  localparam int unsigned CNT_W = EVAL_W;
  logic [CNT_W-1:0] pos_cnt_q [DATA_W];
  logic [CNT_W-1:0] pos_cnt_d [DATA_W];
  logic [CNT_W-1:0] neg_cnt_q [DATA_W];
  logic [CNT_W-1:0] neg_cnt_d [DATA_W];

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      pos_cnt_d[i] = pos_cnt_q[i];
      neg_cnt_d[i] = neg_cnt_q[i];
      if (new_chal) begin
        pos_cnt_d[i] = '0;
        neg_cnt_d[i] = '0;
      end else if (capture) begin
        pos_cnt_d[i] = pos_cnt_q[i] + CNT_W'(bus.rwc_rsp_pos[i]);
        neg_cnt_d[i] = neg_cnt_q[i] + CNT_W'(bus.rwc_rsp_neg[i]);
      end
      vote_pos[i] = (pos_cnt_q[i] > CNT_W'(EVALS / 2));
      vote_neg[i] = (neg_cnt_q[i] > CNT_W'(EVALS / 2));
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      for (int i = 0; i < DATA_W; i++) begin
        pos_cnt_q[i] <= '0;
        neg_cnt_q[i] <= '0;
      end
    end else begin
      pos_cnt_q <= pos_cnt_d;
      neg_cnt_q <= neg_cnt_d;
    end
  end
`else
  // Single evaluation: the captured response is the answer
  logic [DATA_W-1:0] cap_pos_q, cap_pos_d;
  logic [DATA_W-1:0] cap_neg_q, cap_neg_d;

  always_comb begin
    cap_pos_d = capture ? bus.rwc_rsp_pos : cap_pos_q;
    cap_neg_d = capture ? bus.rwc_rsp_neg : cap_neg_q;
    vote_pos  = cap_pos_q;
    vote_neg  = cap_neg_q;
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      cap_pos_q <= '0;
      cap_neg_q <= '0;
    end else begin
      cap_pos_q <= cap_pos_d;
      cap_neg_q <= cap_neg_d;
    end
  end
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.rwc_enable = rwc_enable_q;
  assign bus.rwc_data   = rwc_data_q;
  assign bus.rwc_addr   = rwc_addr_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_pos    = rsp_pos_q;
  assign bus.rsp_neg    = rsp_neg_q;
  assign bus.rsp_idx    = rsp_idx_q;

endmodule

// File: doc/puf_challenge_seq.md
PUF_CHALLENGE_SEQ -- requirements
Module: puf_challenge_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32: challenge and response width.
REQ-002 SHALL have parameter ADDR_W, default 10: challenge address width.
REQ-003 SHALL have parameter NUM_CHAL, default 16: challenges per run, range 1..2^ADDR_W.
REQ-004 SHALL have parameter NUM_EVAL, default 5: evaluations per challenge, odd, 1..15.
REQ-005 SHALL have parameter REST_CYCLES, default 150_000_000: idle cycles after each evaluation, at least 1.
REQ-006 SHALL have port w_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-007 SHALL have port w_resetn, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1 bit: level-sampled run request.
REQ-009 SHALL have port base_data, input, DATA_W bits: challenge data seed.
REQ-010 SHALL have port base_addr, input, ADDR_W bits: first challenge address.
REQ-011 SHALL have port busy, output, 1 bit: run in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-013 SHALL have port rwc_enable, output, 1 bit: one-cycle trigger to the collision generator.
REQ-014 SHALL have port rwc_data, output, DATA_W bits: challenge data to the generator.
REQ-015 SHALL have port rwc_addr, output, ADDR_W bits: challenge address to the generator.
REQ-016 SHALL have port rwc_available, input, 1 bit: generator result valid.
REQ-017 SHALL have ports rwc_rsp_pos and rwc_rsp_neg, input, DATA_W bits each: raw generator responses.
REQ-018 SHALL have port rsp_valid, output, 1 bit: response handshake valid.
REQ-019 SHALL have port rsp_ready, input, 1 bit: response handshake ready.
REQ-020 SHALL have ports rsp_pos and rsp_neg, output, DATA_W bits each: final response.
REQ-021 SHALL have port rsp_idx, output, ADDR_W bits: challenge index of the response.

Function
REQ-022 SHALL implement the states IDLE, FIRE, WAIT, REST, EMIT.
REQ-023 IDLE: start=1 SHALL load base_data and base_addr, clear chal_idx and eval_cnt, and go to FIRE; busy SHALL be 0 only in IDLE.
REQ-024 FIRE SHALL assert rwc_enable for exactly one cycle and go to WAIT.
REQ-025 The challenge SHALL be rwc_addr = (base_addr + chal_idx) mod 2^ADDR_W and rwc_data = base_data rotated left by (chal_idx mod DATA_W).
REQ-026 rwc_addr and rwc_data SHALL hold stable from FIRE until leaving REST.
REQ-027 WAIT SHALL remain in WAIT until rwc_available=1, then capture rwc_rsp_pos and rwc_rsp_neg that cycle and go to REST; an rwc_available seen in any other state SHALL be ignored.
REQ-028 REST SHALL count exactly REST_CYCLES cycles.
REQ-029 At the end of REST, if eval_cnt < NUM_EVAL-1, the block SHALL increment eval_cnt and go to FIRE; otherwise it SHALL go to EMIT.
REQ-030 EMIT SHALL assert rsp_valid, with rsp_pos, rsp_neg and rsp_idx stable until rsp_valid & rsp_ready.
REQ-031 On that handshake, if chal_idx = NUM_CHAL-1, the block SHALL pulse done and go to IDLE.
REQ-032 On that handshake, otherwise, the block SHALL increment chal_idx, clear eval_cnt and go to FIRE.
REQ-033 Held rsp_ready=0 SHALL stall in EMIT indefinitely with no generator activity.
REQ-034 Address SHALL wrap modulo 2^ADDR_W with no error flag, e.g. 0x3FF+1 = 0x000.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 Challenge-to-first-rwc_enable latency SHALL be 1 cycle after the start sample.

Reset
REQ-037 w_resetn=0 at a rising w_clk edge SHALL force IDLE.
REQ-038 Reset SHALL clear all counters and accumulators.
REQ-039 Reset SHALL drive busy, done, rwc_enable and rsp_valid to 0, and rwc_data, rwc_addr, rsp_pos, rsp_neg and rsp_idx to 0.
REQ-040 Reset mid-run SHALL abort without a done or rsp_valid pulse; rwc_enable SHALL be 0 the cycle after reset is applied.

Configuration
REQ-041 With macro PUF_MAJORITY_VOTE_EN defined, the block SHALL accumulate per-bit one-counts of the captured pos/neg over NUM_EVAL evaluations, and set each rsp bit = 1 iff its count > NUM_EVAL/2.
REQ-042 With PUF_MAJORITY_VOTE_EN defined, the counters SHALL clear on entry to each new challenge.
REQ-043 Without PUF_MAJORITY_VOTE_EN, NUM_EVAL SHALL be treated as 1, the rsp outputs SHALL equal the single captured response, and no counter hardware SHALL exist.

Verification
REQ-044 Bench SHALL cover: NUM_CHAL=2, NUM_EVAL=1, REST_CYCLES=4, base_addr=0x005, base_data=0x0000_0001, generator answers 3 cycles after enable -> rwc_addr 0x005 then 0x006, rwc_data 0x1 then 0x2, two responses, done pulse.
REQ-045 Bench SHALL cover: PUF_MAJORITY_VOTE_EN, NUM_EVAL=5, rsp_pos bit0 sequence 1,1,0,1,0 -> rsp_pos[0]=1; sequence 1,0,0,1,0 -> rsp_pos[0]=0.
REQ-046 Bench SHALL cover: base_addr=0x3FF, NUM_CHAL=2 -> second rwc_addr=0x000.
REQ-047 Bench SHALL cover: rsp_ready held 0 for 100 cycles in EMIT -> rsp outputs stable, rwc_enable stays 0, the run proceeds one cycle after rsp_ready=1.
REQ-048 Bench SHALL cover: w_resetn=0 during WAIT, followed by a late rwc_available -> IDLE, busy=0, no rsp_valid, a subsequent start runs normally.
REQ-049 Bench SHALL cover: start pulsed while busy -> no restart, chal_idx sequence unchanged.
